// File: rtl/win_screen_ctrl.sv
// win_screen_ctrl: latches the game result and sequences the blinking win screen.
// Define WIN_SCREEN_AUTO_EXIT_EN to leave WAIT_BTN after HOLD_FRAMES ticks with no press.
module win_screen_ctrl #(
  parameter int HOLD_FRAMES  = 300,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic [1:0] winner,
  input  logic       btn_continue,
  output logic [2:0] player,
  output logic       win_active,
  output logic       win_visible,
  output logic       back_to_menu
);
  localparam int W = $clog2(HOLD_FRAMES + 1);
  localparam logic [W-1:0] HOLD  = W'(HOLD_FRAMES);
  localparam logic [W-1:0] BLINK = W'(BLINK_FRAMES);
  typedef enum logic [2:0] {IDLE, ARM, SHOW, WAIT_BTN, EXIT} state_t;
  state_t state, state_d;
  logic [W-1:0] frame_cnt, frame_d, frame_inc, blink_cnt, blink_d, blink_inc;
  logic [1:0] pend, pend_d;
  logic [2:0] player_d;
  logic btn_q, btn_edge, hold_hit, vis_d;
  assign frame_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + W'(1);
  assign blink_inc = (blink_cnt == '1) ? blink_cnt : blink_cnt + W'(1);
  assign btn_edge  = btn_continue & ~btn_q;
  assign hold_hit  = frame_tick && (frame_inc == HOLD);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = (game_over && winner != 2'd0) ? ARM : IDLE;
      ARM:      state_d = frame_tick ? SHOW : ARM;
      SHOW:     state_d = hold_hit ? WAIT_BTN : SHOW;
`ifdef WIN_SCREEN_AUTO_EXIT_EN
      WAIT_BTN: state_d = (btn_edge || hold_hit) ? EXIT : WAIT_BTN;
`else
      WAIT_BTN: state_d = btn_edge ? EXIT : WAIT_BTN;
`endif
      EXIT:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    frame_d  = frame_cnt;
    blink_d  = blink_cnt;
    vis_d    = win_visible;
    player_d = player;
    pend_d   = pend;
    if (state == IDLE && game_over && winner != 2'd0) pend_d = winner;
    if (state == ARM && frame_tick) begin
      player_d = (pend == 2'd2) ? 3'b010 : (pend == 2'd3) ? 3'b100 : 3'b001;
      vis_d    = 1'b1;
      frame_d  = '0;
      blink_d  = '0;
    end
    if (state == SHOW && frame_tick) begin
      frame_d = frame_inc;
      blink_d = (blink_inc == BLINK) ? '0 : blink_inc;
      vis_d   = (blink_inc == BLINK) ? ~win_visible : win_visible;
      // end of hold: show steadily and restart the frame count for the wait phase
      if (hold_hit) begin
        vis_d   = 1'b1;
        frame_d = '0;
      end
    end
    if (state == WAIT_BTN) begin
      vis_d = 1'b1;
`ifdef WIN_SCREEN_AUTO_EXIT_EN
      if (frame_tick) frame_d = frame_inc;
`endif
    end
    if (state == EXIT) vis_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      player       <= 3'b001;
      win_active   <= 1'b0;
      win_visible  <= 1'b0;
      back_to_menu <= 1'b0;
      frame_cnt    <= '0;
      blink_cnt    <= '0;
      pend         <= 2'd0;
      btn_q        <= 1'b0;
    end else begin
      player       <= player_d;
      win_active   <= state_d != IDLE;
      win_visible  <= vis_d;
      back_to_menu <= state_d == EXIT;
      frame_cnt    <= frame_d;
      blink_cnt    <= blink_d;
      pend         <= pend_d;
      btn_q        <= btn_continue;
    end
endmodule

// File: tb/tb_win_screen_ctrl.sv
// tb_win_screen_ctrl: directed scenarios plus random traffic against a frame-level result model.
module tb_win_screen_ctrl;
  localparam int HOLD = 4, BLINK = 2;
  logic clk = 0, rst_n = 1, frame_tick = 0, game_over = 0, btn_continue = 0;
  logic [1:0] winner = 0;
  logic [2:0] player;
  logic win_active, win_visible, back_to_menu;
  int passed = 0, total = 0, cyc = 0;
  // model: phase 0 idle, 1 armed, 2 showing, 3 waiting, 4 leaving
  int m_phase = 0, m_ticks = 0, m_wticks = 0, m_pend = 0;
  logic [2:0] m_player = 3'b001;
  bit m_prev_btn = 0;

  win_screen_ctrl #(.HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_over(game_over),
    .winner(winner), .btn_continue(btn_continue), .player(player),
    .win_active(win_active), .win_visible(win_visible), .back_to_menu(back_to_menu));

  always #5 clk = ~clk;

  function automatic bit e_active();  return m_phase != 0; endfunction
  function automatic bit e_back();    return m_phase == 4; endfunction
  function automatic bit e_visible();
    if (m_phase == 2) return ((m_ticks / BLINK) % 2) == 0;
    return m_phase >= 3;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pend = 0; m_player = 3'b001; m_prev_btn = 0;
  endtask

  task automatic model_update();
    bit edge_seen;
    edge_seen = btn_continue && !m_prev_btn;
    m_prev_btn = btn_continue;
    case (m_phase)
      0: if (game_over && winner != 0) begin m_pend = winner; m_phase = 1; end
      1: if (frame_tick) begin m_player = 3'b001 << (m_pend - 1); m_ticks = 0; m_phase = 2; end
      2: if (frame_tick) begin
           m_ticks++;
           if (m_ticks == HOLD) begin m_phase = 3; m_wticks = 0; end
         end
      3: if (edge_seen) m_phase = 4;
`ifdef WIN_SCREEN_AUTO_EXIT_EN
         else if (frame_tick) begin m_wticks++; if (m_wticks == HOLD) m_phase = 4; end
`endif
      default: m_phase = 0;
    endcase
  endtask

  task automatic step(input bit go, input logic [1:0] w, input bit btn);
    @(negedge clk);
    game_over = go; winner = w; btn_continue = btn; frame_tick = (cyc % 10 == 9); cyc++;
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic run_to_tick(input bit btn);
    int n = 0;
    do begin step(0, 0, btn); n++; end while (!frame_tick && n < 20);
    total++;
    if (!frame_tick) $display("FAIL tick_wait: no frame_tick within %0d cycles", n); else passed++;
  endtask

  task automatic test_reset();
    #2 rst_n = 0; model_reset();
    #1 total++;
    if ({player, win_active, win_visible, back_to_menu} !== 6'b001_000)
      $display("FAIL reset_assert: got %b want 001000", {player, win_active, win_visible, back_to_menu});
    else passed++;
    repeat (3) step(0, 0, 0);
    @(negedge clk) rst_n = 1;
    step(0, 0, 0);
    total++;
    if ({player, win_active, win_visible, back_to_menu} !== 6'b001_000)
      $display("FAIL reset_release: got %b want 001000", {player, win_active, win_visible, back_to_menu});
    else passed++;
  endtask

  task automatic test_win_p2();
    step(1, 2, 0);
    total++;
    if ({player, win_active, win_visible} !== 5'b001_10)
      $display("FAIL arm: got %b want 00110", {player, win_active, win_visible});
    else passed++;
    run_to_tick(0);
    total++;
    if ({player, win_visible} !== 4'b010_1)
      $display("FAIL show_entry: got %b want 0101", {player, win_visible});
    else passed++;
  endtask

  task automatic test_blink();
    bit exp_vis[4] = '{1, 0, 0, 1};
    for (int k = 0; k < 4; k++) begin
      run_to_tick(1);
      total++;
      if (win_visible !== exp_vis[k])
        $display("FAIL blink_tick%0d: got %b want %b", k + 1, win_visible, exp_vis[k]);
      else passed++;
    end
    total++;
    if (m_phase != 3 || win_active !== 1'b1 || back_to_menu !== 1'b0)
      $display("FAIL enter_wait: model phase %0d active %b back %b want 3 1 0", m_phase, win_active, back_to_menu);
    else passed++;
  endtask

  task automatic test_wait_btn();
    bit early = 0;
    repeat (15) begin step(0, 0, 1); early |= back_to_menu; end
    total++;
    if (early !== 1'b0) $display("FAIL held_btn: got exit %b want 0", early); else passed++;
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
    total++;
    if (back_to_menu !== 1'b1 || win_active !== 1'b1)
      $display("FAIL exit_pulse: got back %b active %b want 1 1", back_to_menu, win_active);
    else passed++;
    step(0, 0, 1);
    total++;
    if ({back_to_menu, win_active, win_visible, player} !== 6'b000_010)
      $display("FAIL after_exit: got %b want 000010", {back_to_menu, win_active, win_visible, player});
    else passed++;
  endtask

  task automatic test_ignore();
    step(1, 0, 0);
    total++;
    if (win_active !== 1'b0) $display("FAIL winner0: got active %b want 0", win_active); else passed++;
    step(1, 3, 0);
    run_to_tick(0);
    total++;
    if (player !== 3'b100) $display("FAIL draw: got %b want 100", player); else passed++;
    step(1, 1, 0);
    step(0, 0, 0);
    total++;
    if (player !== 3'b100 || win_active !== 1'b1)
      $display("FAIL relatch: got player %b active %b want 100 1", player, win_active);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit pulse = 0;
    @(negedge clk) rst_n = 0; model_reset();
    #1 total++;
    if ({player, win_active, win_visible, back_to_menu} !== 6'b001_000)
      $display("FAIL reset_mid: got %b want 001000", {player, win_active, win_visible, back_to_menu});
    else passed++;
    repeat (2) begin step(0, 0, 0); pulse |= back_to_menu; end
    @(negedge clk) rst_n = 1;
    repeat (3) begin step(0, 0, 0); pulse |= back_to_menu; end
    total++;
    if (pulse !== 1'b0) $display("FAIL reset_no_pulse: got %b want 0", pulse); else passed++;
  endtask

  task automatic test_auto_exit();
    step(1, 1, 0);
    repeat (HOLD + 1) run_to_tick(0);
    for (int k = 1; k <= HOLD; k++) begin
      run_to_tick(0);
      total++;
`ifdef WIN_SCREEN_AUTO_EXIT_EN
      if (back_to_menu !== (k == HOLD))
        $display("FAIL auto_exit_tick%0d: got %b want %b", k, back_to_menu, k == HOLD);
      else passed++;
`else
      if (back_to_menu !== 1'b0 || win_active !== 1'b1)
        $display("FAIL no_auto_exit_tick%0d: got back %b active %b want 0 1", k, back_to_menu, win_active);
      else passed++;
`endif
    end
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
  endtask

  task automatic test_random();
    bit btn = 0, go;
    logic [1:0] w;
    for (int i = 0; i < 1500; i++) begin
      go = ($urandom_range(0, 7) == 0);
      w = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      step(go, w, btn);
      total++;
      if (player !== m_player || win_active !== e_active() || win_visible !== e_visible() || back_to_menu !== e_back())
        $display("FAIL random_cyc%0d: got p=%b a=%b v=%b b=%b want p=%b a=%b v=%b b=%b", i,
                 player, win_active, win_visible, back_to_menu, m_player, e_active(), e_visible(), e_back());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_win_p2();
    test_blink();
    test_wait_btn();
    test_ignore();
    test_reset_mid();
    test_auto_exit();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
